regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised successor to the pipeline's GPR/HILO storage: N-read/1-write register file with
//  synchronous clear, byte-strobed writes, write-to-read bypass, per-register pending scoreboard,
//  and an integrated HI/LO pair with bypass. Sits in ID (reads, issue marking) and WB (writes).
// PARAMETERS
//  DATA_W   32  register width in bits (multiple of 8)
//  ADDR_W   5   register index width; NREG = 2**ADDR_W
//  NRD      2   number of read ports
//  BYPASS   1   1: same-cycle write data visible on reads; 0: reads return stored value only
// PORTS
//  clk         in   1              rising-edge clock
//  reset       in   1              synchronous, active-high; clears all state
//  raddr       in   NRD*ADDR_W     read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rdata       out  NRD*DATA_W     read data, port i at [i*DATA_W +: DATA_W]
//  rbusy       out  NRD            1 = addressed register has a pending producer
//  iss_valid   in   1              issue: mark iss_addr pending
//  iss_addr    in   ADDR_W         destination of issued instruction
//  we          in   1              writeback enable, high valid
//  waddr       in   ADDR_W         writeback index
//  wstrb       in   DATA_W/8       byte strobes for writeback
//  wdata       in   DATA_W         writeback data
//  wclr        in   1              with we: also clear pending bit of waddr
//  hi_we       in   1              HI write enable
//  lo_we       in   1              LO write enable
//  wd_hi       in   DATA_W         HI write data
//  wd_lo       in   DATA_W         LO write data
//  rd_hi       out  DATA_W         HI read data
//  rd_lo       out  DATA_W         LO read data
// BEHAVIOUR
//  - Reset: all NREG registers, HI, LO = 0; all pending bits = 0. During reset cycle writes/issues ignored.
//  - Register 0 hardwired: reads 0, rbusy 0; writes and issues to index 0 ignored.
//  - Write: at posedge, if we && waddr!=0, byte k of rf[waddr] <= wdata byte k where wstrb[k]=1.
//  - Read combinational. BYPASS=1 and we && waddr==raddr_i !=0: rdata_i = strobe-merge of wdata
//    over stored value; else stored value. Latency 0; write visible via storage next cycle.
//  - HI/LO: written at posedge on hi_we/lo_we independently; BYPASS=1 forwards wd_hi/wd_lo when enable high.
//  - Scoreboard: pending[iss_addr] <= 1 on iss_valid; pending[waddr] <= 0 on we && wclr.
//    Same index both: set wins (new producer supersedes). rbusy_i = pending[raddr_i], registered
//    value only (no bypass of set/clear in same cycle).
//  - Multiple read ports on same index return identical data/busy.
//  - wstrb all-zero with we: no data change, pending clear still honoured.
// STRUCTURE
//  - Shared package: DATA_W/ADDR_W defaults, REG_ZERO constant, byte-merge function merge_strb().
//  - One sub-module: regfile_sb_rport (one read port mux + bypass + busy), generated NRD times.
//  - Storage, scoreboard, HI/LO in top module.
// TESTING
//  1 reset, then read all 32 regs on both ports -> rdata 0, rbusy 0, rd_hi=rd_lo=0.
//  2 we=1 waddr=5 wstrb=F wdata=DEADBEEF, raddr0=5 same cycle -> rdata0=DEADBEEF (BYPASS=1); next cycle stored.
//  3 reg5=DEADBEEF; write wstrb=4'b0010 wdata=00001200 -> reg5=DEAD12EF.
//  4 write waddr=0 wdata=FFFFFFFF, iss_addr=0 -> raddr=0 reads 0, rbusy 0.
//  5 iss_valid addr 7 -> next cycle rbusy=1; we+wclr addr 7 with iss_valid addr 7 same cycle -> rbusy stays 1;
//    we+wclr alone -> rbusy 0 next cycle.
//  6 hi_we=1 wd_hi=12345678, lo_we=0 -> rd_hi=12345678 immediately, rd_lo unchanged; assert reset mid-sequence -> all 0 next cycle.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared types, defaults and helpers for the regfile_sb register file slice.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package regfile_sb_pkg;

    // Default geometry: 32 x 32-bit general purpose registers.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Index of the hardwired zero register.
    localparam int REG_ZERO   = 0;

    // Widest register the merge helper supports. Callers zero-extend into
    // these types and truncate the result back to their own width.
    localparam int MAX_DATA_W = 256;

    typedef logic [MAX_DATA_W-1:0]   word_max_t;
    typedef logic [MAX_DATA_W/8-1:0] strb_max_t;

    // Byte-strobe merge: for every byte k with strb[k] set, take new_w byte k,
    // otherwise keep old_w byte k.
    function automatic word_max_t merge_strb(
        input word_max_t old_w,
        input word_max_t new_w,
        input strb_max_t strb
    );
        word_max_t res;
        res = old_w;
        for (int k = 0; k < MAX_DATA_W/8; k++) begin
            if (strb[k]) begin
                res[k*8 +: 8] = new_w[k*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_sb_rport.sv
// One register file read port: storage mux, write-to-read bypass and pending-bit lookup.
// Latency: 0 cycles, purely combinational from raddr/write bus to rdata/rbusy.
// Backpressure: none; the port always answers.
module regfile_sb_rport
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1,
    parameter int NREG   = 1 << ADDR_W
)(
    input  logic [ADDR_W-1:0]      raddr,
    input  logic [NREG*DATA_W-1:0] rf_flat,
    input  logic [NREG-1:0]        pending,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W/8-1:0]    wstrb,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   rbusy
);

    logic [DATA_W-1:0] stored;
    logic              is_zero;
    logic              hit;

    assign stored  = rf_flat[int'(raddr)*DATA_W +: DATA_W];
    assign is_zero = (raddr == ADDR_W'(REG_ZERO));
    // A same-cycle writeback to this index is forwarded only when bypass is built in.
    assign hit     = (BYPASS != 0) && we && (waddr == raddr);

    // Select stored or forwarded data; register zero always reads as zero and never busy.
    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (!is_zero) begin
            rbusy = pending[raddr];
            if (hit) begin
                rdata = DATA_W'(merge_strb(word_max_t'(stored),
                                           word_max_t'(wdata),
                                           strb_max_t'(wstrb)));
            end else begin
                rdata = stored;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// N-read/1-write GPR file with byte strobes, bypass, pending scoreboard and HI/LO pair.
// Latency: reads 0 cycles (combinational); writes land in storage at the next rising edge.
// Backpressure: none; reads, issues and writebacks are accepted every cycle.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  wclr,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_W-1:0]     wd_hi,
    input  logic [DATA_W-1:0]     wd_lo,
    output logic [DATA_W-1:0]     rd_hi,
    output logic [DATA_W-1:0]     rd_lo
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0]      rf [NREG];
    logic [NREG*DATA_W-1:0] rf_flat;
    logic [NREG-1:0]        pending;
    logic [DATA_W-1:0]      hi_q;
    logic [DATA_W-1:0]      lo_q;

    logic wr_ok;
    logic iss_ok;
    logic clr_ok;

    // Index zero is hardwired, so writes, issues and clears aimed at it are dropped here.
    assign wr_ok  = we && (waddr != ADDR_W'(REG_ZERO));
    assign clr_ok = wr_ok && wclr;
    assign iss_ok = iss_valid && (iss_addr != ADDR_W'(REG_ZERO));

    // Register storage: synchronous clear, then byte-strobed writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                rf[r] <= '0;
            end
        end else if (wr_ok) begin
            rf[waddr] <= DATA_W'(merge_strb(word_max_t'(rf[waddr]),
                                            word_max_t'(wdata),
                                            strb_max_t'(wstrb)));
        end
    end

    // Pending scoreboard: the issue set is applied after the writeback clear so a new
    // producer issued in the same cycle as the old one retires keeps the register busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (clr_ok) begin
                pending[waddr] <= 1'b0;
            end
            if (iss_ok) begin
                pending[iss_addr] <= 1'b1;
            end
        end
    end

    // HI/LO pair: independent write enables, cleared with the rest of the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) begin
                hi_q <= wd_hi;
            end
            if (lo_we) begin
                lo_q <= wd_lo;
            end
        end
    end

    // HI/LO read: forward the incoming value when its enable is high and bypass is built in.
    always_comb begin
        rd_hi = hi_q;
        rd_lo = lo_q;
        if ((BYPASS != 0) && hi_we) begin
            rd_hi = wd_hi;
        end
        if ((BYPASS != 0) && lo_we) begin
            rd_lo = wd_lo;
        end
    end

    // Flatten storage so every read port sees the whole file on one packed bus.
    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign rf_flat[g*DATA_W +: DATA_W] = rf[g];
    end

    // One independent read port per lane; identical addresses give identical results.
    for (genvar i = 0; i < NRD; i++) begin : g_rport
        regfile_sb_rport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS),
            .NREG   (NREG)
        ) u_rport (
            .raddr   (raddr[i*ADDR_W +: ADDR_W]),
            .rf_flat (rf_flat),
            .pending (pending),
            .we      (we),
            .waddr   (waddr),
            .wstrb   (wstrb),
            .wdata   (wdata),
            .rdata   (rdata[i*DATA_W +: DATA_W]),
            .rbusy   (rbusy[i])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed cases plus a randomised phase against a reference model.
// Latency: outputs checked 2 time units after inputs change, well before the next rising edge.
// Backpressure: n/a.
module tb_regfile_sb;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NREG = 32;
    localparam int SW   = DW/8;

    logic              clk;
    logic              reset;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic              iss_valid;
    logic [AW-1:0]     iss_addr;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [SW-1:0]     wstrb;
    logic [DW-1:0]     wdata;
    logic              wclr;
    logic              hi_we;
    logic              lo_we;
    logic [DW-1:0]     wd_hi;
    logic [DW-1:0]     wd_lo;
    logic [DW-1:0]     rd_hi;
    logic [DW-1:0]     rd_lo;

    regfile_sb #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NRD    (NRD),
        .BYPASS (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .we        (we),
        .waddr     (waddr),
        .wstrb     (wstrb),
        .wdata     (wdata),
        .wclr      (wclr),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wd_hi     (wd_hi),
        .wd_lo     (wd_lo),
        .rd_hi     (rd_hi),
        .rd_lo     (rd_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {S_RD0, S_RD1, S_BUSY0, S_BUSY1, S_HI, S_LO} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state, updated once per cycle at the conceptual rising edge.
    logic [DW-1:0]   mrf [NREG];
    logic [NREG-1:0] mpend;
    logic [DW-1:0]   mhi;
    logic [DW-1:0]   mlo;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, got, want);
        end
    endtask

    task automatic expect_out(input string tag, input sel_e sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.sel)
                S_RD0:   obs = rdata[0*DW +: DW];
                S_RD1:   obs = rdata[1*DW +: DW];
                S_BUSY0: obs = {31'b0, rbusy[0]};
                S_BUSY1: obs = {31'b0, rbusy[1]};
                S_HI:    obs = rd_hi;
                default: obs = rd_lo;
            endcase
            check_val(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [DW-1:0] mmerge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                             input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = o;
        for (int k = 0; k < SW; k++) begin
            if (s[k]) r[k*8 +: 8] = n[k*8 +: 8];
        end
        return r;
    endfunction

    task automatic idle();
        reset     = 1'b0;
        raddr     = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        we        = 1'b0;
        waddr     = '0;
        wstrb     = '0;
        wdata     = '0;
        wclr      = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wd_hi     = '0;
        wd_lo     = '0;
    endtask

    // Called at a falling edge with inputs already driven: optionally predict outputs,
    // check them, advance the model past the rising edge, and return at the next falling edge.
    task automatic tick(input bit use_model);
        logic [AW-1:0] a;
        logic [DW-1:0] r;
        if (use_model) begin
            for (int p = 0; p < NRD; p++) begin
                a = raddr[p*AW +: AW];
                if (a == 0)                    r = '0;
                else if (we && waddr == a)     r = mmerge(mrf[a], wdata, wstrb);
                else                           r = mrf[a];
                expect_out((p == 0) ? "rnd_rd0" : "rnd_rd1", (p == 0) ? S_RD0 : S_RD1, r);
                expect_out((p == 0) ? "rnd_busy0" : "rnd_busy1", (p == 0) ? S_BUSY0 : S_BUSY1,
                           {31'b0, (a != 0) && mpend[a]});
            end
            expect_out("rnd_hi", S_HI, hi_we ? wd_hi : mhi);
            expect_out("rnd_lo", S_LO, lo_we ? wd_lo : mlo);
        end
        #2;
        drain();
        if (reset) begin
            for (int i = 0; i < NREG; i++) mrf[i] = '0;
            mpend = '0;
            mhi   = '0;
            mlo   = '0;
        end else begin
            if (we && waddr != 0) mrf[waddr] = mmerge(mrf[waddr], wdata, wstrb);
            if (we && wclr && waddr != 0) mpend[waddr] = 1'b0;
            if (iss_valid && iss_addr != 0) mpend[iss_addr] = 1'b1;
            if (hi_we) mhi = wd_hi;
            if (lo_we) mlo = wd_lo;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        @(negedge clk);

        // Reset cycle, then sweep every register on both ports.
        reset = 1'b1;
        tick(0);
        idle();
        for (int a = 0; a < NREG; a++) begin
            raddr = {5'(NREG-1-a), 5'(a)};
            expect_out("rst_rd0", S_RD0, 32'h0);
            expect_out("rst_rd1", S_RD1, 32'h0);
            expect_out("rst_busy0", S_BUSY0, 32'h0);
            expect_out("rst_busy1", S_BUSY1, 32'h0);
            expect_out("rst_hi", S_HI, 32'h0);
            expect_out("rst_lo", S_LO, 32'h0);
            tick(0);
        end

        // Full-word write with same-cycle bypass, then the stored value.
        idle();
        we = 1'b1; waddr = 5'd5; wstrb = 4'hF; wdata = 32'hDEADBEEF;
        raddr = {5'd0, 5'd5};
        expect_out("byp_rd0", S_RD0, 32'hDEADBEEF);
        expect_out("byp_rd1_zero", S_RD1, 32'h0);
        tick(0);
        idle();
        raddr = {5'd5, 5'd5};
        expect_out("stored_rd0", S_RD0, 32'hDEADBEEF);
        expect_out("stored_rd1", S_RD1, 32'hDEADBEEF);
        tick(0);

        // Single-byte strobe merge, bypassed and then stored.
        idle();
        we = 1'b1; waddr = 5'd5; wstrb = 4'b0010; wdata = 32'h00001200;
        raddr = {5'd5, 5'd5};
        expect_out("strb_byp_rd0", S_RD0, 32'hDEAD12EF);
        expect_out("strb_byp_rd1", S_RD1, 32'hDEAD12EF);
        tick(0);
        idle();
        raddr = {5'd0, 5'd5};
        expect_out("strb_stored", S_RD0, 32'hDEAD12EF);
        tick(0);

        // Writes and issues to register zero are ignored.
        idle();
        we = 1'b1; waddr = 5'd0; wstrb = 4'hF; wdata = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_addr = 5'd0;
        raddr = {5'd0, 5'd0};
        expect_out("r0_byp", S_RD0, 32'h0);
        expect_out("r0_busy", S_BUSY0, 32'h0);
        tick(0);
        idle();
        expect_out("r0_after", S_RD1, 32'h0);
        expect_out("r0_busy_after", S_BUSY1, 32'h0);
        tick(0);

        // Scoreboard: set is registered, set wins over a same-cycle clear.
        idle();
        iss_valid = 1'b1; iss_addr = 5'd7; raddr = {5'd0, 5'd7};
        expect_out("sb_set_same_cycle", S_BUSY0, 32'h0);
        tick(0);
        idle();
        we = 1'b1; wclr = 1'b1; waddr = 5'd7; wstrb = 4'h0; wdata = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_addr = 5'd7; raddr = {5'd7, 5'd7};
        expect_out("sb_busy0", S_BUSY0, 32'h1);
        expect_out("sb_busy1", S_BUSY1, 32'h1);
        expect_out("sb_nostrb_rd", S_RD0, 32'h0);
        tick(0);
        idle();
        we = 1'b1; wclr = 1'b1; waddr = 5'd7; wstrb = 4'hF; wdata = 32'h11112222;
        raddr = {5'd0, 5'd7};
        expect_out("sb_set_wins", S_BUSY0, 32'h1);
        expect_out("sb_clr_byp", S_RD0, 32'h11112222);
        tick(0);
        idle();
        raddr = {5'd7, 5'd7};
        expect_out("sb_cleared", S_BUSY0, 32'h0);
        expect_out("sb_cleared_rd1", S_RD1, 32'h11112222);
        tick(0);

        // Zero strobes with clear: data untouched, pending still cleared.
        idle();
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick(0);
        idle();
        we = 1'b1; wclr = 1'b1; waddr = 5'd9; wstrb = 4'h0; wdata = 32'hA5A5A5A5;
        raddr = {5'd0, 5'd9};
        expect_out("z_strb_busy", S_BUSY0, 32'h1);
        tick(0);
        idle();
        raddr = {5'd0, 5'd9};
        expect_out("z_strb_rd", S_RD0, 32'h0);
        expect_out("z_strb_clr", S_BUSY0, 32'h0);
        tick(0);

        // HI/LO bypass and independence, then reset mid-sequence.
        idle();
        hi_we = 1'b1; wd_hi = 32'h12345678; wd_lo = 32'hAAAAAAAA;
        expect_out("hi_byp", S_HI, 32'h12345678);
        expect_out("lo_untouched", S_LO, 32'h0);
        tick(0);
        idle();
        iss_valid = 1'b1; iss_addr = 5'd12;
        expect_out("hi_stored", S_HI, 32'h12345678);
        tick(0);
        idle();
        lo_we = 1'b1; wd_lo = 32'h87654321; raddr = {5'd0, 5'd12};
        expect_out("lo_byp", S_LO, 32'h87654321);
        expect_out("hi_kept", S_HI, 32'h12345678);
        expect_out("busy12", S_BUSY0, 32'h1);
        tick(0);
        idle();
        reset = 1'b1;
        tick(0);
        idle();
        raddr = {5'd12, 5'd5};
        expect_out("rst2_rd0", S_RD0, 32'h0);
        expect_out("rst2_busy1", S_BUSY1, 32'h0);
        expect_out("rst2_hi", S_HI, 32'h0);
        expect_out("rst2_lo", S_LO, 32'h0);
        tick(0);

        // Randomised traffic on a narrow index range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            idle();
            reset     = ($urandom_range(0, 63) == 0);
            we        = $urandom_range(0, 1) == 1;
            waddr     = 5'($urandom_range(0, 7));
            wstrb     = 4'($urandom_range(0, 15));
            wdata     = $urandom;
            wclr      = $urandom_range(0, 1) == 1;
            iss_valid = $urandom_range(0, 1) == 1;
            iss_addr  = 5'($urandom_range(0, 7));
            raddr[0*AW +: AW] = ($urandom_range(0, 1) == 1) ? waddr : 5'($urandom_range(0, 7));
            raddr[1*AW +: AW] = ($urandom_range(0, 3) == 0) ? raddr[0*AW +: AW]
                                                           : 5'($urandom_range(0, 7));
            hi_we     = $urandom_range(0, 1) == 1;
            lo_we     = $urandom_range(0, 1) == 1;
            wd_hi     = $urandom;
            wd_lo     = $urandom;
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
